rtc_calendar_core: RTL and testbench

//  Parametrised real-time clock/calendar (hh:mm:ss, yy-mm-dd) with built-in 1 Hz prescaler, per-field set mode,

---
 rtl/rtc_calendar_core_if.sv | 26 ++
 rtl/rtc_calendar_core.sv | 193 +++++++++++++++++++
 tb/tb_rtc_calendar_core.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_calendar_core_if.sv
// Control/status bundle for rtc_calendar_core: set-mode controls in, BCD digits and pulses out.
// RTC_ALARM_EN adds alarm_sel/alarm_on inputs and the alarm output.
interface rtc_calendar_core_if;
    logic        run;
    logic [2:0]  set_sel;
    logic        inc;
    logic        disp_date;
    logic [23:0] digits;
    logic        tick_1hz;
    logic        chime;
`ifdef RTC_ALARM_EN
    logic        alarm_sel;
    logic        alarm_on;
    logic        alarm;

    modport master (output run, set_sel, inc, disp_date, alarm_sel, alarm_on,
                    input  digits, tick_1hz, chime, alarm);
    modport slave  (input  run, set_sel, inc, disp_date, alarm_sel, alarm_on,
                    output digits, tick_1hz, chime, alarm);
`else
    modport master (output run, set_sel, inc, disp_date,
                    input  digits, tick_1hz, chime);
    modport slave  (input  run, set_sel, inc, disp_date,
                    output digits, tick_1hz, chime);
`endif
endinterface

// File: rtl/rtc_calendar_core.sv
// Real-time clock/calendar with 1 Hz prescaler, set mode, Gregorian leap rule and hourly chime.
// Outputs are registered (1-cycle latency); optional alarm is enabled by defining RTC_ALARM_EN.
module rtc_calendar_core #(
    parameter int CLK_DIV    = 50_000_000,
    parameter int YEAR_BASE  = 2000,
    parameter int RESET_YEAR = 16
) (
    input  logic               clk,
    input  logic               rst,
    rtc_calendar_core_if.slave bus
);
    localparam int              CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt, cnt_n;
    logic [6:0]    sec, minute, hour, day, month, year;
    logic [6:0]    sec_n, minute_n, hour_n, day_n, month_n, year_n;
    logic          tick, set_inc;
    logic          tick_q, chime_q, chime_n;
    logic [23:0]   digits_q, digits_n;
`ifdef RTC_ALARM_EN
    logic [6:0]    alm_min, alm_hour, alm_min_n, alm_hour_n;
    logic [5:0]    alarm_cnt, alarm_cnt_n;
    logic          alarm_q, alarm_n;
`endif

    // Full year is kept at 16 bits so the century terms of the leap rule are exact.
    function automatic logic is_leap(input logic [6:0] yr);
        logic [15:0] y;
        y = 16'(YEAR_BASE) + {9'd0, yr};
        return ((y % 16'd4 == 16'd0) && (y % 16'd100 != 16'd0)) || (y % 16'd400 == 16'd0);
    endfunction

    function automatic logic [6:0] dim(input logic [6:0] mo, input logic [6:0] yr);
        case (mo)
            7'd4, 7'd6, 7'd9, 7'd11: dim = 7'd30;
            7'd2:                    dim = is_leap(yr) ? 7'd29 : 7'd28;
            default:                 dim = 7'd31;
        endcase
    endfunction

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] top,
                                            input logic [6:0] lo);
        return (v >= top) ? lo : v + 7'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign tick    = bus.run && (cnt == CNT_MAX);
    assign set_inc = bus.inc && !bus.run;

    always_comb begin
        cnt_n    = bus.run ? ((cnt == CNT_MAX) ? '0 : cnt + CW'(1)) : '0;
        sec_n    = sec;
        minute_n = minute;
        hour_n   = hour;
        day_n    = day;
        month_n  = month;
        year_n   = year;
        chime_n  = chime_q;
`ifdef RTC_ALARM_EN
        alm_min_n  = alm_min;
        alm_hour_n = alm_hour;
`endif
        if (tick) begin
            // Each carry only fires when every lower field wraps in the same tick.
            sec_n = wrap_inc(sec, 7'd59, 7'd0);
            if (sec == 7'd59) begin
                minute_n = wrap_inc(minute, 7'd59, 7'd0);
                if (minute == 7'd59) begin
                    hour_n = wrap_inc(hour, 7'd23, 7'd0);
                    if (hour == 7'd23) begin
                        day_n = wrap_inc(day, dim(month, year), 7'd1);
                        if (day >= dim(month, year)) begin
                            month_n = wrap_inc(month, 7'd12, 7'd1);
                            if (month == 7'd12)
                                year_n = wrap_inc(year, 7'd99, 7'd0);
                        end
                    end
                end
            end
            chime_n = (sec_n == 7'd0) && (minute_n == 7'd0);
        end else if (set_inc) begin
            chime_n = 1'b0;
            case (bus.set_sel)
                3'd0: sec_n = wrap_inc(sec, 7'd59, 7'd0);
                3'd1: begin
`ifdef RTC_ALARM_EN
                    if (bus.alarm_sel) alm_min_n = wrap_inc(alm_min, 7'd59, 7'd0);
                    else               minute_n  = wrap_inc(minute, 7'd59, 7'd0);
`else
                    minute_n = wrap_inc(minute, 7'd59, 7'd0);
`endif
                end
                3'd2: begin
`ifdef RTC_ALARM_EN
                    if (bus.alarm_sel) alm_hour_n = wrap_inc(alm_hour, 7'd23, 7'd0);
                    else               hour_n     = wrap_inc(hour, 7'd23, 7'd0);
`else
                    hour_n = wrap_inc(hour, 7'd23, 7'd0);
`endif
                end
                3'd3: day_n = wrap_inc(day, dim(month, year), 7'd1);
                3'd4: begin
                    month_n = wrap_inc(month, 7'd12, 7'd1);
                    if (day > dim(month_n, year)) day_n = dim(month_n, year);
                end
                3'd5: begin
                    year_n = wrap_inc(year, 7'd99, 7'd0);
                    if (day > dim(month, year_n)) day_n = dim(month, year_n);
                end
                default: ;
            endcase
        end

        if (bus.disp_date)
            digits_n = {to_bcd(year), to_bcd(month), to_bcd(day)};
`ifdef RTC_ALARM_EN
        else if (bus.alarm_sel)
            digits_n = {to_bcd(alm_hour), to_bcd(alm_min), 8'h00};
`endif
        else
            digits_n = {to_bcd(hour), to_bcd(minute), to_bcd(sec)};
    end

`ifdef RTC_ALARM_EN
    // alarm_cnt counts ticks since the match; the 60th tick ends the alarm.
    always_comb begin
        alarm_n     = alarm_q;
        alarm_cnt_n = alarm_cnt;
        if (!bus.alarm_on) begin
            alarm_n     = 1'b0;
            alarm_cnt_n = '0;
        end else if (tick) begin
            if (hour_n == alm_hour && minute_n == alm_min && sec_n == 7'd0) begin
                alarm_n     = 1'b1;
                alarm_cnt_n = '0;
            end else if (alarm_q) begin
                alarm_n     = (alarm_cnt != 6'd59);
                alarm_cnt_n = (alarm_cnt == 6'd59) ? 6'd0 : alarm_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alm_min   <= '0;
            alm_hour  <= '0;
            alarm_cnt <= '0;
            alarm_q   <= 1'b0;
        end else begin
            alm_min   <= alm_min_n;
            alm_hour  <= alm_hour_n;
            alarm_cnt <= alarm_cnt_n;
            alarm_q   <= alarm_n;
        end
    end

    assign bus.alarm = alarm_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sec      <= 7'd0;
            minute   <= 7'd0;
            hour     <= 7'd0;
            day      <= 7'd1;
            month    <= 7'd1;
            year     <= 7'(RESET_YEAR);
            tick_q   <= 1'b0;
            chime_q  <= 1'b0;
            digits_q <= 24'h0;
        end else begin
            cnt      <= cnt_n;
            sec      <= sec_n;
            minute   <= minute_n;
            hour     <= hour_n;
            day      <= day_n;
            month    <= month_n;
            year     <= year_n;
            tick_q   <= tick;
            chime_q  <= chime_n;
            digits_q <= digits_n;
        end
    end

    assign bus.digits   = digits_q;
    assign bus.tick_1hz = tick_q;
    assign bus.chime    = chime_q;
endmodule

// File: tb/tb_rtc_calendar_core.sv
// Bench for rtc_calendar_core: two instances (YEAR_BASE 2000 and 2100) driven in lockstep.
`timescale 1ns/1ps
module tb_rtc_calendar_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rtc_calendar_core_if b0();
    rtc_calendar_core_if b1();

    rtc_calendar_core #(.CLK_DIV(4), .YEAR_BASE(2000), .RESET_YEAR(16)) u_dut (
        .clk(clk), .rst(rst), .bus(b0));
    rtc_calendar_core #(.CLK_DIV(4), .YEAR_BASE(2100), .RESET_YEAR(16)) u_dut2100 (
        .clk(clk), .rst(rst), .bus(b1));

    typedef struct { string name; int dut; int sig; logic [23:0] val; } exp_t;
    typedef struct { logic [2:0] sel; int n; logic disp; logic [23:0] digits; } vec_t;

    exp_t sb[$];
    vec_t vt[19];
    int   checks = 0;
    int   errors = 0;

    // sig: 0 digits, 1 tick_1hz, 2 chime
    function automatic logic [23:0] actual(input int dut, input int sig);
        if (dut == 0)
            return (sig == 0) ? b0.digits : (sig == 1) ? {23'd0, b0.tick_1hz} : {23'd0, b0.chime};
        else
            return (sig == 0) ? b1.digits : (sig == 1) ? {23'd0, b1.tick_1hz} : {23'd0, b1.chime};
    endfunction

    task automatic exp_push(input string name, input int sig, input logic [23:0] v0,
                            input logic [23:0] v1);
        sb.push_back('{name, 0, sig, v0});
        sb.push_back('{name, 1, sig, v1});
    endtask

    task automatic exp_both(input string name, input int sig, input logic [23:0] v);
        exp_push(name, sig, v, v);
    endtask

    task automatic check_now();
        exp_t e;
        logic [23:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = actual(e.dut, e.sig);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s dut%0d sig%0d got %h want %h", e.name, e.dut, e.sig, a, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_run(input logic v);
        b0.run = v;
        b1.run = v;
    endtask

    task automatic set_disp(input logic v);
        b0.disp_date = v;
        b1.disp_date = v;
    endtask

    task automatic set_inc(input logic [2:0] sel, input logic v);
        b0.set_sel = sel;
        b1.set_sel = sel;
        b0.inc     = v;
        b1.inc     = v;
    endtask

    task automatic drv_inc(input logic [2:0] sel, input int n);
        for (int i = 0; i < n; i++) begin
            set_inc(sel, 1'b1);
            cyc(1);
            set_inc(sel, 1'b0);
            cyc(1);
        end
    endtask

    task automatic run_ticks_check(input string name);
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            exp_both($sformatf("%s_tick%0d", name, k), 1, (k == 4) ? 24'd1 : 24'd0);
            check_now();
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{3'd0, 56, 1'b0, 24'h000059};
        vt[1]  = '{3'd0,  1, 1'b0, 24'h000000};
        vt[2]  = '{3'd1, 61, 1'b0, 24'h000100};
        vt[3]  = '{3'd2, 25, 1'b0, 24'h010100};
        vt[4]  = '{3'd6,  5, 1'b0, 24'h010100};
        vt[5]  = '{3'd7,  3, 1'b0, 24'h010100};
        vt[6]  = '{3'd3, 30, 1'b1, 24'h160131};
        vt[7]  = '{3'd4,  1, 1'b1, 24'h160229};
        vt[8]  = '{3'd5,  1, 1'b1, 24'h170228};
        vt[9]  = '{3'd3,  1, 1'b1, 24'h170201};
        vt[10] = '{3'd3, 27, 1'b1, 24'h170228};
        vt[11] = '{3'd5,  6, 1'b1, 24'h230228};
        vt[12] = '{3'd4, 11, 1'b1, 24'h230128};
        vt[13] = '{3'd3,  3, 1'b1, 24'h230131};
        vt[14] = '{3'd4,  1, 1'b1, 24'h230228};
        vt[15] = '{3'd5,  1, 1'b1, 24'h240228};
        vt[16] = '{3'd3,  1, 1'b1, 24'h240229};
        vt[17] = '{3'd5,  1, 1'b1, 24'h250228};
        vt[18] = '{3'd2,  0, 1'b0, 24'h010100};

        set_run(1'b1);
        set_disp(1'b0);
        set_inc(3'd0, 1'b0);
        cyc(2);
        exp_both("rst_digits", 0, 24'h0);
        exp_both("rst_tick", 1, 24'd0);
        exp_both("rst_chime", 2, 24'd0);
        check_now();

        // Prescaler: ticks every 4 cycles after reset release, none while halted.
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            exp_both($sformatf("pre_tick%0d", k), 1, (k % 4 == 0) ? 24'd1 : 24'd0);
            check_now();
        end
        cyc(1);
        exp_both("pre_sec3", 0, 24'h000003);
        check_now();
        set_run(1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            exp_both($sformatf("halt_tick%0d", k), 1, 24'd0);
            check_now();
        end

        // Set-mode vectors: wraps, no-op selects, day clamping on month/year steps.
        for (int i = 0; i < 19; i++) begin
            set_disp(vt[i].disp);
            drv_inc(vt[i].sel, vt[i].n);
            cyc(1);
            exp_both($sformatf("vec%0d_digits", i), 0, vt[i].digits);
            exp_both($sformatf("vec%0d_chime", i), 2, 24'd0);
            check_now();
        end

        // Full rollover 23:59:59 31-12-99 -> 00:00:00 01-01-00 with chime.
        drv_inc(3'd0, 59);
        drv_inc(3'd1, 58);
        drv_inc(3'd2, 22);
        drv_inc(3'd4, 10);
        drv_inc(3'd3, 3);
        drv_inc(3'd5, 74);
        set_disp(1'b1);
        cyc(1);
        exp_both("roll_pre", 0, 24'h991231);
        check_now();
        set_run(1'b1);
        run_ticks_check("roll");
        exp_both("roll_chime_on", 2, 24'd1);
        check_now();
        cyc(1);
        exp_both("roll_date", 0, 24'h000101);
        exp_both("roll_chime_p5", 2, 24'd1);
        check_now();
        set_disp(1'b0);
        cyc(1);
        exp_both("roll_time", 0, 24'h000000);
        check_now();
        cyc(1);
        exp_both("roll_chime_p7", 2, 24'd1);
        check_now();
        cyc(1);
        exp_both("roll_tick2", 1, 24'd1);
        exp_both("roll_chime_off", 2, 24'd0);
        check_now();
        set_run(1'b0);
        cyc(1);
        exp_both("roll_sec1", 0, 24'h000001);
        check_now();

        // Feb 28 -> 29 in 2000, -> Mar 1 in 2100.
        drv_inc(3'd0, 58);
        drv_inc(3'd1, 59);
        drv_inc(3'd2, 23);
        drv_inc(3'd4, 1);
        drv_inc(3'd3, 27);
        set_disp(1'b1);
        set_run(1'b1);
        run_ticks_check("cent");
        cyc(1);
        exp_push("cent_date", 0, 24'h000229, 24'h000301);
        check_now();
        cyc(1);

        // Async reset mid-count with prescaler at 2.
        rst = 1'b1;
        set_run(1'b0);
        exp_both("arst_digits", 0, 24'h0);
        exp_both("arst_chime", 2, 24'd0);
        #1;
        check_now();
        cyc(1);
        rst = 1'b0;
        cyc(1);
        exp_both("arst_date", 0, 24'h160101);
        exp_both("arst_tick", 1, 24'd0);
        check_now();

        // inc ignored while running; first tick exactly 4 cycles after run rises.
        set_run(1'b1);
        for (int k = 1; k <= 4; k++) begin
            set_inc(3'd0, (k <= 3) ? 1'b1 : 1'b0);
            cyc(1);
            exp_both($sformatf("runinc_tick%0d", k), 1, (k == 4) ? 24'd1 : 24'd0);
            check_now();
        end
        set_run(1'b0);
        set_disp(1'b0);
        cyc(1);
        exp_both("runinc_sec", 0, 24'h000001);
        check_now();

        // Leap years 24 vs 23 on the tick, chime cleared by a set inc.
        drv_inc(3'd5, 8);
        drv_inc(3'd4, 1);
        drv_inc(3'd3, 27);
        drv_inc(3'd2, 23);
        drv_inc(3'd1, 59);
        drv_inc(3'd0, 58);
        set_disp(1'b1);
        set_run(1'b1);
        run_ticks_check("leap24");
        set_run(1'b0);
        cyc(1);
        exp_both("leap24_date", 0, 24'h240229);
        exp_both("leap24_chime", 2, 24'd1);
        check_now();
        drv_inc(3'd5, 99);
        cyc(1);
        exp_both("leap23_clamp", 0, 24'h230228);
        exp_both("inc_clr_chime", 2, 24'd0);
        check_now();
        drv_inc(3'd2, 23);
        drv_inc(3'd1, 59);
        drv_inc(3'd0, 59);
        set_run(1'b1);
        cyc(4);
        exp_both("leap23_tick", 1, 24'd1);
        check_now();
        set_run(1'b0);
        cyc(1);
        exp_both("leap23_date", 0, 24'h230301);
        exp_both("leap23_chime", 2, 24'd1);
        check_now();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
